// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared RV32I branch encodings, branch-type enum and result struct
//
// Purpose: funct3 encodings for conditional branches, an opcode-independent
// branch-type enum, the registered branch result record, and a decode helper.
// Ports: none (package).

package rv32i_pkg;

    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        BR_EQ,
        BR_NE,
        BR_LT,
        BR_GE,
        BR_LTU,
        BR_GEU,
        BR_JAL,
        BR_JALR,
        BR_ILLEGAL
    } br_type_e;

    typedef struct packed {
        logic        taken;
        logic [31:0] target;
        logic [31:0] link;
        logic        misalign;
        logic        illegal;
    } br_result_t;

    // Jumps override funct3; the two reserved funct3 codes (010, 011) decode as illegal.
    function automatic br_type_e decode_br_type(input logic [2:0] funct3,
                                                input logic       jal,
                                                input logic       jalr);
        br_type_e t;
        if (jal) begin
            t = BR_JAL;
        end else if (jalr) begin
            t = BR_JALR;
        end else begin
            case (funct3)
                FUNCT3_BEQ:  t = BR_EQ;
                FUNCT3_BNE:  t = BR_NE;
                FUNCT3_BLT:  t = BR_LT;
                FUNCT3_BGE:  t = BR_GE;
                FUNCT3_BLTU: t = BR_LTU;
                FUNCT3_BGEU: t = BR_GEU;
                default:     t = BR_ILLEGAL;
            endcase
        end
        return t;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - 32-bit combinational comparator for branch conditions
//
// Purpose: produce less-than (signed or unsigned) and equality of two operands.
// Ports:
//   a, b       in  32  operands
//   is_signed  in  1   1 = two's-complement ordering, 0 = unsigned ordering
//   lt         out 1   a < b under the selected ordering
//   eq         out 1   a == b

module branch_cmp (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic        lt,
    output logic        eq
);

    always_comb begin
        eq = (a == b);
        if (is_signed) begin
            lt = ($signed(a) < $signed(b));
        end else begin
            lt = (a < b);
        end
    end

endmodule

// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - two-stage pipelined RV32I branch/jump resolution unit
//
// Purpose: resolve conditional branches, JAL and JALR into taken/target/link
// with illegal-funct3 and misaligned-target flags, through a two-stage
// valid/ready pipeline (S1 captures the request, S2 holds the result).
// Ports:
//   i_clk, i_rst                   clock, synchronous active-high reset
//   i_valid / o_ready              request handshake
//   i_funct3, i_jal, i_jalr        branch condition / jump select
//   i_rs1, i_rs2, i_pc, i_imm      operands, PC, sign-extended immediate
//   i_flush                        drop everything in flight
//   o_valid / i_ready              result handshake
//   o_taken, o_target, o_link,
//   o_misalign, o_illegal          result fields

module branch_unit
    import rv32i_pkg::*;
#(
    parameter int ALIGN_CHECK = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [2:0]  i_funct3,
    input  logic        i_jal,
    input  logic        i_jalr,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic        o_taken,
    output logic [31:0] o_target,
    output logic [31:0] o_link,
    output logic        o_misalign,
    output logic        o_illegal
);

    // S1: captured request
    logic        s1_valid;
    logic [2:0]  s1_funct3;
    logic        s1_jal;
    logic        s1_jalr;
    logic [31:0] s1_rs1;
    logic [31:0] s1_rs2;
    logic [31:0] s1_pc;
    logic [31:0] s1_imm;

    // S2: resolved result
    logic        s2_valid;
    br_result_t  s2_res;

    br_type_e    br_type;
    br_result_t  res;
    logic        cmp_lt;
    logic        cmp_eq;
    logic        cmp_signed;
    logic        cond_taken;
    logic        s2_load;
    logic        s1_accept;

    // funct3[1] is 0 for BLT/BGE and 1 for BLTU/BGEU.
    assign cmp_signed = ~s1_funct3[1];

    branch_cmp u_cmp (
        .a         (s1_rs1),
        .b         (s1_rs2),
        .is_signed (cmp_signed),
        .lt        (cmp_lt),
        .eq        (cmp_eq)
    );

    always_comb begin
        br_type    = decode_br_type(s1_funct3, s1_jal, s1_jalr);
        cond_taken = 1'b0;
        res        = '0;

        case (br_type)
            BR_EQ:   cond_taken = cmp_eq;
            BR_NE:   cond_taken = ~cmp_eq;
            BR_LT:   cond_taken = cmp_lt;
            BR_GE:   cond_taken = ~cmp_lt;
            BR_LTU:  cond_taken = cmp_lt;
            BR_GEU:  cond_taken = ~cmp_lt;
            BR_JAL:  cond_taken = 1'b1;
            BR_JALR: cond_taken = 1'b1;
            default: cond_taken = 1'b0;
        endcase

        if (br_type == BR_JALR) begin
            res.target = (s1_rs1 + s1_imm) & 32'hFFFF_FFFE;
        end else begin
            res.target = s1_pc + s1_imm;
        end
        res.link     = s1_pc + 32'd4;
        res.taken    = cond_taken;
        res.illegal  = (br_type == BR_ILLEGAL);
        res.misalign = (ALIGN_CHECK != 0) && cond_taken && (res.target[1:0] != 2'b00);
    end

    // S2 loads when empty or draining; S1 advances exactly when S2 loads.
    assign s2_load   = s1_valid && (!s2_valid || i_ready);
    assign o_ready   = !i_rst && (!s1_valid || s2_load);
    assign s1_accept = i_valid && o_ready && !i_flush;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            s2_res    <= '0;
            s1_funct3 <= '0;
            s1_jal    <= 1'b0;
            s1_jalr   <= 1'b0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_pc     <= '0;
            s1_imm    <= '0;
        end else if (i_flush) begin
            // A result handed over this same cycle was already consumed.
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_load) begin
                s2_valid <= 1'b1;
                s2_res   <= res;
            end else if (s2_valid && i_ready) begin
                s2_valid <= 1'b0;
            end

            if (s1_accept) begin
                s1_valid  <= 1'b1;
                s1_funct3 <= i_funct3;
                s1_jal    <= i_jal;
                s1_jalr   <= i_jalr;
                s1_rs1    <= i_rs1;
                s1_rs2    <= i_rs2;
                s1_pc     <= i_pc;
                s1_imm    <= i_imm;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end

    // Outputs are forced to zero during reset, including the first reset cycle.
    assign o_valid    = !i_rst && s2_valid;
    assign o_taken    = !i_rst && s2_res.taken;
    assign o_misalign = !i_rst && s2_res.misalign;
    assign o_illegal  = !i_rst && s2_res.illegal;
    assign o_target   = i_rst ? 32'd0 : s2_res.target;
    assign o_link     = i_rst ? 32'd0 : s2_res.link;

endmodule
